// File: rtl/zxbus_status_port_if.sv
// ---------------------------------------------------------------------------
// zxbus_status_port_if
//   ZX-bus I/O signal bundle between the ZX host side and the status port.
//   master : host side (drives address, strobes, write data)
//   slave  : status port (drives read data, buffer controls, IORQ block)
// Signals
//   zxa[7:0]      I/O address low byte (asynchronous to clk)
//   zxiorq_n      IORQ strobe, active low
//   zxrd_n        RD strobe, active low
//   zxwr_n        WR strobe, active low
//   zxid_in[7:0]  data from the ZX bus
//   zxid_out[7:0] data to the ZX bus
//   zxid_oe       1 = drive zxid with zxid_out
//   zxbusin       bus buffer direction, 1 = ZX->FPGA, 0 = FPGA->ZX
//   zxbusena_n    bus buffer enable, active low
//   zxblkiorq_n   low while zxa addresses one of our ports
// ---------------------------------------------------------------------------
interface zxbus_status_port_if;
    logic [7:0] zxa;
    logic       zxiorq_n;
    logic       zxrd_n;
    logic       zxwr_n;
    logic [7:0] zxid_in;
    logic [7:0] zxid_out;
    logic       zxid_oe;
    logic       zxbusin;
    logic       zxbusena_n;
    logic       zxblkiorq_n;

    modport master (
        output zxa, zxiorq_n, zxrd_n, zxwr_n, zxid_in,
        input  zxid_out, zxid_oe, zxbusin, zxbusena_n, zxblkiorq_n
    );

    modport slave (
        input  zxa, zxiorq_n, zxrd_n, zxwr_n, zxid_in,
        output zxid_out, zxid_oe, zxbusin, zxbusena_n, zxblkiorq_n
    );
endinterface

// File: rtl/zxbus_status_port.sv
// ---------------------------------------------------------------------------
// zxbus_status_port
//   ZX-bus I/O responder exposing the RAM tester status to the ZX host through
//   an index/data register pair. The host writes the index port to select a
//   register, then reads/writes the data port; data port accesses advance the
//   index by one (wrapping 7 -> 0).
//
// Parameters
//   IDX_PORT  zxa value of the index port (write only)
//   DAT_PORT  zxa value of the data window port (read/write)
//   ID_BYTE   constant returned at index 6
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   bus              ZX-bus signals (zxbus_status_port_if.slave)
//   tst_done         tester finished at least one pass
//   tst_err          tester saw a mismatch
//   tst_pass_cnt     completed pass count (16 bit)
//   tst_err_addr     first failing address (22 bit)
//   cmd_restart      one-clock pulse requesting a tester restart
//   led_mode         LED display mode select
//
// Register map (data port, at current index)
//   0  R {tst_done, tst_err, 4'b0, led_mode}
//      W bit7=1 -> cmd_restart pulse, bits1:0 -> led_mode
//   1  R pass_cnt[7:0]       2  R pass_cnt[15:8]
//   3  R err_addr[7:0]       4  R err_addr[15:8]   5  R {2'b0, err_addr[21:16]}
//   6  R ID_BYTE             7  R/W scratch
//
// Build option
//   ZXSP_SNAPSHOT_EN : reading index 1 latches pass_cnt[15:8] for index 2 and
//   reading index 3 latches err_addr[21:8] for indices 4/5, so multi-byte
//   values read back coherently. Without it, indices 2/4/5 return live inputs.
// ---------------------------------------------------------------------------
module zxbus_status_port #(
    parameter logic [7:0] IDX_PORT = 8'hB3,
    parameter logic [7:0] DAT_PORT = 8'hB4,
    parameter logic [7:0] ID_BYTE  = 8'h5A
) (
    input  logic                    clk,
    input  logic                    rst,
    zxbus_status_port_if.slave      bus,
    input  logic                    tst_done,
    input  logic                    tst_err,
    input  logic [15:0]             tst_pass_cnt,
    input  logic [21:0]             tst_err_addr,
    output logic                    cmd_restart,
    output logic [1:0]              led_mode
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_WAITEND = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Strobe synchronisers (strobes are asynchronous to clk). Reset to the
    // inactive (high) level so no spurious edge appears after reset.
    // -----------------------------------------------------------------------
    logic [1:0] r_iorq_sync;
    logic [1:0] r_rd_sync;
    logic [1:0] r_wr_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iorq_sync <= 2'b11;
            r_rd_sync   <= 2'b11;
            r_wr_sync   <= 2'b11;
        end else begin
            r_iorq_sync <= {r_iorq_sync[0], bus.zxiorq_n};
            r_rd_sync   <= {r_rd_sync[0],   bus.zxrd_n};
            r_wr_sync   <= {r_wr_sync[0],   bus.zxwr_n};
        end
    end

    logic w_iorq_s, w_rd_s, w_wr_s;
    assign w_iorq_s = r_iorq_sync[1];
    assign w_rd_s   = r_rd_sync[1];
    assign w_wr_s   = r_wr_sync[1];

    // RD and WR low together is not a legal cycle: treat it as no access.
    logic w_rd_act, w_wr_act;
    assign w_rd_act = ~w_iorq_s & ~w_rd_s &  w_wr_s;
    assign w_wr_act = ~w_iorq_s & ~w_wr_s &  w_rd_s;

    logic r_rd_act_d, r_wr_act_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_act_d <= 1'b0;
            r_wr_act_d <= 1'b0;
        end else begin
            r_rd_act_d <= w_rd_act;
            r_wr_act_d <= w_wr_act;
        end
    end

    logic w_rd_rise, w_wr_rise;
    assign w_rd_rise = w_rd_act & ~r_rd_act_d;
    assign w_wr_rise = w_wr_act & ~r_wr_act_d;

    // zxa is sampled only at the rising edge of an access, by which time the
    // host has held it stable for the whole synchroniser delay.
    logic w_hit_idx, w_hit_dat;
    assign w_hit_idx = (bus.zxa == IDX_PORT);
    assign w_hit_dat = (bus.zxa == DAT_PORT);

    // Block the host's own IORQ decoding while either port is addressed.
    assign bus.zxblkiorq_n = ~(w_hit_idx | w_hit_dat);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t     r_state;
    logic [2:0] r_index;
    logic [7:0] r_scratch;
    logic [1:0] r_led_mode;
    logic       r_cmd_restart;
    logic [7:0] r_zxid_out;
    logic       r_zxid_oe;
    logic       r_zxbusin;
    logic       r_zxbusena_n;

`ifdef ZXSP_SNAPSHOT_EN
    logic [7:0]  r_snap_pc_hi;
    logic [13:0] r_snap_ea_hi;
`endif

    // -----------------------------------------------------------------------
    // Read data mux
    // -----------------------------------------------------------------------
    logic [7:0] w_rd_data;

    always_comb begin
        w_rd_data = 8'h00;
        case (r_index)
            3'd0: w_rd_data = {tst_done, tst_err, 4'b0000, r_led_mode};
            3'd1: w_rd_data = tst_pass_cnt[7:0];
`ifdef ZXSP_SNAPSHOT_EN
            3'd2: w_rd_data = r_snap_pc_hi;
            3'd3: w_rd_data = tst_err_addr[7:0];
            3'd4: w_rd_data = r_snap_ea_hi[7:0];
            3'd5: w_rd_data = {2'b00, r_snap_ea_hi[13:8]};
`else
            3'd2: w_rd_data = tst_pass_cnt[15:8];
            3'd3: w_rd_data = tst_err_addr[7:0];
            3'd4: w_rd_data = tst_err_addr[15:8];
            3'd5: w_rd_data = {2'b00, tst_err_addr[21:16]};
`endif
            3'd6: w_rd_data = ID_BYTE;
            3'd7: w_rd_data = r_scratch;
            default: w_rd_data = 8'h00;
        endcase
    end

    // -----------------------------------------------------------------------
    // Access FSM with registered bus controls. The async reset releases the
    // bus immediately even in the middle of a host read.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_index       <= 3'd0;
            r_scratch     <= 8'h00;
            r_led_mode    <= 2'd0;
            r_cmd_restart <= 1'b0;
            r_zxid_out    <= 8'h00;
            r_zxid_oe     <= 1'b0;
            r_zxbusin     <= 1'b1;
            r_zxbusena_n  <= 1'b1;
`ifdef ZXSP_SNAPSHOT_EN
            r_snap_pc_hi  <= 8'h00;
            r_snap_ea_hi  <= 14'h0000;
`endif
        end else begin
            // Only set in the single cycle a data write is captured, so the
            // pulse is one clock regardless of how long WR stays low.
            r_cmd_restart <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rd_rise) begin
                        if (w_hit_dat) begin
                            r_zxid_out   <= w_rd_data;
                            r_zxid_oe    <= 1'b1;
                            r_zxbusin    <= 1'b0;
                            r_zxbusena_n <= 1'b0;
                            r_state      <= ST_RD;
`ifdef ZXSP_SNAPSHOT_EN
                            if (r_index == 3'd1)
                                r_snap_pc_hi <= tst_pass_cnt[15:8];
                            if (r_index == 3'd3)
                                r_snap_ea_hi <= tst_err_addr[21:8];
`endif
                        end else begin
                            // Includes reads of the write-only index port.
                            r_state <= ST_WAITEND;
                        end
                    end else if (w_wr_rise) begin
                        if (w_hit_idx) begin
                            r_index      <= bus.zxid_in[2:0];
                            r_zxbusin    <= 1'b1;
                            r_zxbusena_n <= 1'b0;
                            r_state      <= ST_WR;
                        end else if (w_hit_dat) begin
                            case (r_index)
                                3'd0: begin
                                    r_cmd_restart <= bus.zxid_in[7];
                                    r_led_mode    <= bus.zxid_in[1:0];
                                end
                                3'd7:    r_scratch <= bus.zxid_in;
                                default: ; // read-only index: write dropped
                            endcase
                            r_index      <= r_index + 3'd1;
                            r_zxbusin    <= 1'b1;
                            r_zxbusena_n <= 1'b0;
                            r_state      <= ST_WR;
                        end else begin
                            r_state <= ST_WAITEND;
                        end
                    end
                end

                ST_RD: begin
                    if (!w_rd_act) begin
                        r_zxid_oe    <= 1'b0;
                        r_zxbusin    <= 1'b1;
                        r_zxbusena_n <= 1'b1;
                        r_index      <= r_index + 3'd1;
                        r_state      <= ST_IDLE;
                    end
                end

                ST_WR: begin
                    if (!w_wr_act) begin
                        r_zxbusena_n <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                ST_WAITEND: begin
                    if (!w_rd_act && !w_wr_act)
                        r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.zxid_out   = r_zxid_out;
    assign bus.zxid_oe    = r_zxid_oe;
    assign bus.zxbusin    = r_zxbusin;
    assign bus.zxbusena_n = r_zxbusena_n;
    assign cmd_restart    = r_cmd_restart;
    assign led_mode       = r_led_mode;

endmodule
